// File: rtl/bg_rom_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bg_rom_arbiter
//
// Shares one single-port background index ROM between the real-time video
// fetch (vid) and an auxiliary reader (aux, e.g. a tile/effect engine).
// Video normally wins. Aux is guaranteed a slot once it has been denied for
// STARVE_MAX consecutive cycles. Read data coming back from the ROM is routed
// to whichever requester issued the read, using a tag pipeline that matches
// the ROM latency.
//
// Parameters
//   ADDR_W      ROM address width
//   DATA_W      ROM word (palette index) width
//   ROM_LAT     ROM read latency in vga_clk cycles, address edge to q valid (1..3)
//   STARVE_MAX  consecutive denied aux cycles before aux is forced a slot (1..255)
//
// Ports
//   vga_clk      in   sole clock, all state on the rising edge
//   reset        in   synchronous, active-high
//   vid_req      in   video read request, held until vid_gnt
//   vid_addr     in   video read address, stable while vid_req
//   vid_gnt      out  video request accepted this cycle (combinational)
//   vid_rvalid   out  vid_rdata valid (registered)
//   vid_rdata    out  video read data, zero when not valid
//   aux_req      in   aux read request, held until aux_gnt
//   aux_addr     in   aux read address, stable while aux_req
//   aux_gnt      out  aux request accepted this cycle (combinational)
//   aux_rvalid   out  aux_rdata valid (registered)
//   aux_rdata    out  aux read data, zero when not valid
//   rom_address  out  to ROM address pin
//   rom_q        in   from ROM q pin
//   vid_overrun  out  sticky: a video request was denied at least once
// -----------------------------------------------------------------------------
module bg_rom_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 5,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic              vid_overrun
);

    // Starvation threshold in the width of the counter.
    localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

    // Saturating increment: the counter never runs past the threshold, so a
    // long aux denial cannot wrap it back to a small value.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] limit);
        logic [7:0] res;
        if (cnt >= limit) begin
            res = limit;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

    logic               force_aux_s;
    logic               vid_gnt_s;
    logic               aux_gnt_s;
    logic [ADDR_W-1:0]  rom_address_s;
    logic [ADDR_W-1:0]  hold_addr_r;
    logic [7:0]         starve_cnt_r;
    logic [ROM_LAT-1:0] tag_vid_r;
    logic [ROM_LAT-1:0] tag_aux_r;
    logic               vid_overrun_r;
    logic [DATA_W-1:0]  vid_rdata_s;
    logic [DATA_W-1:0]  aux_rdata_s;

    // Arbitration: video wins unless aux has starved long enough. No read is
    // launched while reset is asserted, so nothing enters the tag pipeline then.
    always_comb begin
        force_aux_s = (starve_cnt_r == STARVE_LIMIT);
        aux_gnt_s   = 1'b0;
        vid_gnt_s   = 1'b0;
        if (reset) begin
            aux_gnt_s = 1'b0;
            vid_gnt_s = 1'b0;
        end else begin
            aux_gnt_s = aux_req & (~vid_req | force_aux_s);
            vid_gnt_s = vid_req & ~aux_gnt_s;
        end
    end

    // ROM address mux: the granted requester drives the pin; otherwise the last
    // address is replayed so the ROM input does not toggle while idle.
    always_comb begin
        rom_address_s = hold_addr_r;
        if (vid_gnt_s) begin
            rom_address_s = vid_addr;
        end else if (aux_gnt_s) begin
            rom_address_s = aux_addr;
        end else begin
            rom_address_s = hold_addr_r;
        end
    end

    // Remember the address last presented to the ROM.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hold_addr_r <= '0;
        end else begin
            hold_addr_r <= rom_address_s;
        end
    end

    // Count consecutive cycles in which aux asked and was refused.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            starve_cnt_r <= 8'd0;
        end else if (aux_req && !aux_gnt_s) begin
            starve_cnt_r <= sat_inc(starve_cnt_r, STARVE_LIMIT);
        end else begin
            starve_cnt_r <= 8'd0;
        end
    end

    // Owner tags travel alongside the ROM read; the last stage lines up with
    // rom_q, so its bits are the registered rvalid outputs. Reset drops every
    // in-flight tag, which silently discards those reads.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            tag_vid_r <= '0;
            tag_aux_r <= '0;
        end else begin
            tag_vid_r[0] <= vid_gnt_s;
            tag_aux_r[0] <= aux_gnt_s;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vid_r[i] <= tag_vid_r[i-1];
                tag_aux_r[i] <= tag_aux_r[i-1];
            end
        end
    end

    // Sticky flag: any cycle where video asked but was not served.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vid_overrun_r <= 1'b0;
        end else if (vid_req && !vid_gnt_s) begin
            vid_overrun_r <= 1'b1;
        end else begin
            vid_overrun_r <= vid_overrun_r;
        end
    end

    // Steer ROM data to its owner; the other requester sees zero.
    always_comb begin
        vid_rdata_s = '0;
        aux_rdata_s = '0;
        if (tag_vid_r[ROM_LAT-1]) begin
            vid_rdata_s = rom_q;
        end else begin
            vid_rdata_s = '0;
        end
        if (tag_aux_r[ROM_LAT-1]) begin
            aux_rdata_s = rom_q;
        end else begin
            aux_rdata_s = '0;
        end
    end

    assign vid_gnt     = vid_gnt_s;
    assign aux_gnt     = aux_gnt_s;
    assign rom_address = rom_address_s;
    assign vid_rvalid  = tag_vid_r[ROM_LAT-1];
    assign aux_rvalid  = tag_aux_r[ROM_LAT-1];
    assign vid_rdata   = vid_rdata_s;
    assign aux_rdata   = aux_rdata_s;
    assign vid_overrun = vid_overrun_r;

endmodule

// File: tb/tb_bg_rom_arbiter.sv
`timescale 1ns/1ps
// Bench for bg_rom_arbiter. Three instances with different latency / starvation
// settings share one clock; each has its own ROM model and response queue.
//   inst0: ROM_LAT=1, STARVE_MAX=8
//   inst1: ROM_LAT=3, STARVE_MAX=1
//   inst2: ROM_LAT=2, STARVE_MAX=8
module tb_bg_rom_arbiter;
    localparam int AW = 17;
    localparam int DW = 5;
    localparam int NI = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int smax_of(input int i);
        case (i)
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // ROM contents: a fixed scramble of the address.
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10] ^ {3'b000, a[16:15]} ^ 5'd19;
    endfunction

    logic          vga_clk = 1'b0;
    logic          rst      [NI];
    logic          vid_req  [NI];
    logic          aux_req  [NI];
    logic [AW-1:0] vid_addr [NI];
    logic [AW-1:0] aux_addr [NI];

    wire           vid_gnt_w    [NI];
    wire           aux_gnt_w    [NI];
    wire           vid_rvalid_w [NI];
    wire           aux_rvalid_w [NI];
    wire           vid_ovr_w    [NI];
    wire  [DW-1:0] vid_rdata_w  [NI];
    wire  [DW-1:0] aux_rdata_w  [NI];
    wire  [AW-1:0] rom_addr_w   [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected read responses: {due_cycle[25:0], owner_is_vid, data[4:0]}
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    logic [31:0] sb2 [$];

    logic [AW-1:0] exp_hold [NI];
    logic          exp_ovr  [NI];

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        localparam int LAT  = lat_of(g);
        localparam int SMAX = smax_of(g);
        logic [AW-1:0] apipe [LAT];
        logic [DW-1:0] rom_q;
        logic          vr_d = 1'b0;
        logic          vg_d = 1'b0;
        logic          ar_d = 1'b0;
        logic          ag_d = 1'b0;
        logic [AW-1:0] va_d = '0;
        logic [AW-1:0] aa_d = '0;

        // ROM model with LAT cycles from address edge to q.
        always @(posedge vga_clk) begin
            apipe[0] <= rom_addr_w[g];
            for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
        end
        assign rom_q = rom_f(apipe[LAT-1]);

        // Requester protocol: address must stay put while a request waits.
        always @(posedge vga_clk) begin
            if (!rst[g] && vr_d && !vg_d && vid_req[g]) begin
                total++;
                if (vid_addr[g] != va_d) begin
                    bad++;
                    $display("FAIL inst%0d vid_addr_stable: got %0d, required %0d", g, vid_addr[g], va_d);
                end
            end
            if (!rst[g] && ar_d && !ag_d && aux_req[g]) begin
                total++;
                if (aux_addr[g] != aa_d) begin
                    bad++;
                    $display("FAIL inst%0d aux_addr_stable: got %0d, required %0d", g, aux_addr[g], aa_d);
                end
            end
            vr_d <= vid_req[g];
            vg_d <= vid_gnt_w[g];
            va_d <= vid_addr[g];
            ar_d <= aux_req[g];
            ag_d <= aux_gnt_w[g];
            aa_d <= aux_addr[g];
        end

        bg_rom_arbiter #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .ROM_LAT   (LAT),
            .STARVE_MAX(SMAX)
        ) u_dut (
            .vga_clk    (vga_clk),
            .reset      (rst[g]),
            .vid_req    (vid_req[g]),
            .vid_addr   (vid_addr[g]),
            .vid_gnt    (vid_gnt_w[g]),
            .vid_rvalid (vid_rvalid_w[g]),
            .vid_rdata  (vid_rdata_w[g]),
            .aux_req    (aux_req[g]),
            .aux_addr   (aux_addr[g]),
            .aux_gnt    (aux_gnt_w[g]),
            .aux_rvalid (aux_rvalid_w[g]),
            .aux_rdata  (aux_rdata_w[g]),
            .rom_address(rom_addr_w[g]),
            .rom_q      (rom_q),
            .vid_overrun(vid_ovr_w[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic qpush(input int i, input logic [31:0] v);
        case (i)
            0:       sb0.push_back(v);
            1:       sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic logic [31:0] qpop(input int i);
        case (i)
            0:       return sb0.pop_front();
            1:       return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    // One clock cycle of stimulus on instance idx with the hand-derived grant
    // outcome (ev/ea). pe=0 marks a read that is expected never to return.
    task automatic step(input int idx, input bit r, input bit vr, input logic [AW-1:0] va,
                        input bit ar, input logic [AW-1:0] aa, input bit ev, input bit ea,
                        input bit pe, input string tn);
        logic [AW-1:0] ea_addr;
        logic [31:0]   due;
        @(posedge vga_clk);
        #1;
        chk($sformatf("inst%0d %s vid_overrun", idx, tn), {31'd0, vid_ovr_w[idx]}, {31'd0, exp_ovr[idx]});
        rst[idx]      = r;
        vid_req[idx]  = vr;
        vid_addr[idx] = va;
        aux_req[idx]  = ar;
        aux_addr[idx] = aa;
        #1;
        chk($sformatf("inst%0d %s vid_gnt", idx, tn), {31'd0, vid_gnt_w[idx]}, {31'd0, ev});
        chk($sformatf("inst%0d %s aux_gnt", idx, tn), {31'd0, aux_gnt_w[idx]}, {31'd0, ea});
        if (ev)      ea_addr = va;
        else if (ea) ea_addr = aa;
        else         ea_addr = exp_hold[idx];
        chk($sformatf("inst%0d %s rom_address", idx, tn), {15'd0, rom_addr_w[idx]}, {15'd0, ea_addr});
        due = cyc + lat_of(idx);
        if (ev && pe) qpush(idx, {due[25:0], 1'b1, rom_f(va)});
        if (ea && pe) qpush(idx, {due[25:0], 1'b0, rom_f(aa)});
        exp_hold[idx] = r ? '0 : ea_addr;
        exp_ovr[idx]  = r ? 1'b0 : (exp_ovr[idx] | (vr & ~ev));
    endtask

    task automatic idle(input int idx, input string tn);
        step(idx, 0, 0, exp_hold[idx], 0, exp_hold[idx], 0, 0, 1, tn);
    endtask

    // Response monitor: every rvalid must match the oldest expected entry,
    // including the exact cycle it lands in.
    always @(negedge vga_clk) begin : mon
        logic [31:0] c32;
        logic [31:0] got;
        logic [31:0] e;
        for (int i = 0; i < NI; i++) begin
            c32 = cyc;
            if (vid_rvalid_w[i] && aux_rvalid_w[i]) begin
                total++;
                bad++;
                $display("FAIL inst%0d both_rvalid: got vid=1 aux=1, expected at most one", i);
            end else if (vid_rvalid_w[i] || aux_rvalid_w[i]) begin
                if (qsize(i) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL inst%0d spurious_rvalid: got vid=%0b aux=%0b at cycle %0d, expected none",
                             i, vid_rvalid_w[i], aux_rvalid_w[i], cyc);
                end else begin
                    e   = qpop(i);
                    got = vid_rvalid_w[i] ? {c32[25:0], 1'b1, vid_rdata_w[i]}
                                          : {c32[25:0], 1'b0, aux_rdata_w[i]};
                    chk($sformatf("inst%0d read_resp", i), got, e);
                end
            end
            if (!vid_rvalid_w[i]) chk($sformatf("inst%0d vid_rdata_idle", i), {27'd0, vid_rdata_w[i]}, 32'd0);
            if (!aux_rvalid_w[i]) chk($sformatf("inst%0d aux_rdata_idle", i), {27'd0, aux_rdata_w[i]}, 32'd0);
        end
    end

    initial begin
        logic [AW-1:0] va;
        logic [AW-1:0] aa;
        bit            ga;
        for (int i = 0; i < NI; i++) begin
            rst[i]      = 1'b1;
            vid_req[i]  = 1'b0;
            aux_req[i]  = 1'b0;
            vid_addr[i] = '0;
            aux_addr[i] = '0;
            exp_hold[i] = '0;
            exp_ovr[i]  = 1'b0;
        end
        repeat (2) @(posedge vga_clk);
        #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        // Reset state: no grants, address 0, overrun clear.
        for (int i = 0; i < NI; i++) idle(i, "reset_state");

        // T1: video only, addresses 0,1,2 back to back.
        for (int a = 0; a < 3; a++) begin
            va = AW'(a);
            step(0, 0, 1, va, 0, '0, 1, 0, 1, "t1");
        end
        idle(0, "t1_end");

        // T2: aux only at the top of the image.
        step(0, 0, 0, '0, 1, 17'd83999, 0, 1, 1, "t2");
        idle(0, "t2_end");

        // T6: one read at 500, then ten idle cycles holding the address.
        step(0, 0, 1, 17'd500, 0, '0, 1, 0, 1, "t6");
        for (int n = 0; n < 10; n++) idle(0, "t6_idle");

        // T3: both held 20 cycles -> aux forced on cycles 8 and 17.
        va = 17'd1000;
        aa = 17'd2000;
        for (int i = 0; i < 20; i++) begin
            ga = (i == 8) || (i == 17);
            step(0, 0, 1, va, 1, aa, !ga, ga, 1, "t3");
            if (ga) aa = aa + 17'd1;
            else    va = va + 17'd1;
        end
        idle(0, "t3_end");

        // aux drops exactly when it would be forced: video served, count cleared.
        va = 17'd3000;
        aa = 17'd3100;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, va, 1, aa, 1, 0, 1, "auxdrop_pre");
            va = va + 17'd1;
        end
        step(0, 0, 1, va, 0, aa, 1, 0, 1, "auxdrop_force");
        va = va + 17'd1;
        step(0, 0, 1, va, 1, aa, 1, 0, 1, "auxdrop_after");
        idle(0, "auxdrop_end");

        // T4: ROM_LAT=3, STARVE_MAX=1 -> strict alternation vid, aux.
        va = 17'd4000;
        aa = 17'd5000;
        for (int i = 0; i < 8; i++) begin
            ga = (i % 2) == 1;
            step(1, 0, 1, va, 1, aa, !ga, ga, 1, "t4");
            if (ga) aa = aa + 17'd7;
            else    va = va + 17'd3;
        end
        idle(1, "t4_end");

        // T5: ROM_LAT=2; build overrun and a partial starve count, reset with a
        // read in flight, then confirm a clean restart.
        va = 17'd6000;
        aa = 17'd7000;
        for (int i = 0; i < 12; i++) begin
            ga = (i == 8);
            step(2, 0, 1, va, 1, aa, !ga, ga, (i != 11), "t5_pre");
            if (ga) aa = aa + 17'd1;
            else    va = va + 17'd1;
        end
        step(2, 1, 0, va, 0, aa, 0, 0, 1, "t5_reset");
        va = 17'd8000;
        aa = 17'd9000;
        for (int i = 0; i < 9; i++) begin
            ga = (i == 8);
            step(2, 0, 1, va, 1, aa, !ga, ga, 1, "t5_post");
            if (ga) aa = aa + 17'd1;
            else    va = va + 17'd1;
        end
        idle(2, "t5_end");

        // Drain and confirm nothing expected is still outstanding.
        repeat (6) @(posedge vga_clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("inst%0d responses_outstanding", i), 32'(qsize(i)), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
